// File: rtl/zjh_ctrl_pkg.sv
// rtl/zjh_ctrl_pkg.sv - shared types and helpers for the mod-N counter sequencer
package zjh_ctrl_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'hF;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

  // (16 - n) mod 16; n = 0 stands for a modulus of 16 and yields 0
  function automatic logic [CNT_W-1:0] preload(input logic [CNT_W-1:0] n);
    return CNT_MAX - n + 4'd1;
  endfunction

endpackage

// File: rtl/zjh_shadow_cnt.sv
// rtl/zjh_shadow_cnt.sv - load/increment/hold copy of the external counter
module zjh_shadow_cnt
  import zjh_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] value,
  output logic             mismatch
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= value + 4'd1;
    end
  end

  assign mismatch = (q != value);

endmodule

// File: rtl/zjh_mod_n_ctrl.sv
// rtl/zjh_mod_n_ctrl.sv - drives a 161-style counter as a start/pause/stop modulo-N counter
module zjh_mod_n_ctrl
  import zjh_ctrl_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              MR,
  input  logic              Start,
  input  logic              Stop,
  input  logic [CNT_W-1:0]  Mod_N,
  input  logic [CNT_W-1:0]  Q_in,
  input  logic              TC_in,
  output logic              Cep,
  output logic              Cet,
  output logic              PE,
  output logic [CNT_W-1:0]  D,
  output logic              Wrap,
  output logic [WRAP_W-1:0] Wrap_cnt,
  output logic              Busy,
  output logic              Err
);

  state_t           state;
  logic [CNT_W-1:0] d_reg;
  logic             load_r;
  logic             run_r;
  logic [CNT_W-1:0] shadow;
  logic             mismatch;
  logic             sh_load;
  logic             sh_inc;

  assign sh_load = (state == LOAD) || ((state == RUN) && TC_in);
  assign sh_inc  = (state == RUN);

  zjh_shadow_cnt u_shadow (
    .clk      (Clk),
    .rst_n    (MR),
    .load     (sh_load),
    .inc      (sh_inc),
    .load_val (d_reg),
    .q        (Q_in),
    .value    (shadow),
    .mismatch (mismatch)
  );

  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state    <= IDLE;
      d_reg    <= '0;
      load_r   <= 1'b0;
      run_r    <= 1'b0;
      Wrap     <= 1'b0;
      Wrap_cnt <= '0;
      Busy     <= 1'b0;
      Err      <= 1'b0;
    end else begin
      Wrap <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Stop && (Mod_N != 4'd1)) begin
            state  <= LOAD;
            d_reg  <= preload(Mod_N);
            load_r <= 1'b1;
            Busy   <= 1'b1;
          end else if (Start && (Mod_N == 4'd1)) begin
            Err <= 1'b1;
          end
        end
        LOAD: begin
          state    <= RUN;
          load_r   <= 1'b0;
          run_r    <= 1'b1;
          Err      <= 1'b0;
          Wrap_cnt <= '0;
        end
        RUN: begin
          if (TC_in) begin
            Wrap     <= 1'b1;
            Wrap_cnt <= Wrap_cnt + 1'b1;
          end
          if (mismatch) Err <= 1'b1;
          if (Stop) begin
            state <= HOLD;
            run_r <= 1'b0;
          end
        end
        HOLD: begin
          if (mismatch) Err <= 1'b1;
          if (Stop) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else if (Start) begin
            state <= RUN;
            run_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Cep = run_r;
  assign Cet = run_r;
  assign D   = d_reg;
  // TC_in feeds PE combinationally so the reload lands on the overflow edge
  assign PE  = ~(load_r | (run_r & TC_in));

endmodule

// File: tb/tb_zjh_mod_n_ctrl.sv
// tb/tb_zjh_mod_n_ctrl.sv - directed bench: controller driving a behavioural 161 counter
module tb_zjh_mod_n_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] mod_n;
  logic [3:0] q;
  logic [3:0] q_in;
  logic       tc_in;
  logic       cep, cet, pe;
  logic [3:0] d;
  logic       wrap;
  logic [7:0] wrap_cnt;
  logic       busy;
  logic       err;
  logic       fault_en;
  logic [3:0] fault_val;

  int checks = 0;
  int errors = 0;

  zjh_mod_n_ctrl dut (
    .Clk      (clk),
    .MR       (rst_n),
    .Start    (start),
    .Stop     (stop),
    .Mod_N    (mod_n),
    .Q_in     (q_in),
    .TC_in    (tc_in),
    .Cep      (cep),
    .Cet      (cet),
    .PE       (pe),
    .D        (d),
    .Wrap     (wrap),
    .Wrap_cnt (wrap_cnt),
    .Busy     (busy),
    .Err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 4'd0;
    else if (!pe) q <= d;
    else if (cep && cet) q <= q + 4'd1;
  end

  assign tc_in = (q == 4'hF) && cet;
  assign q_in  = fault_en ? fault_val : q;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    start = 1'b0; stop = 1'b0; mod_n = 4'd10; fault_en = 1'b0; fault_val = 4'd0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_run(input logic [3:0] n);
    mod_n = n;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({pe, cep, cet, d, busy, err, wrap, wrap_cnt} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: pe=%b cep=%b cet=%b d=%0d busy=%b err=%b wrap=%b wrap_cnt=%0d, want pe=1 rest 0",
               pe, cep, cet, d, busy, err, wrap, wrap_cnt);
    end
    // mid-run asynchronous reset after one completed period
    start_run(4'd10);
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (wrap_cnt !== 8'd1) begin
      errors++; $display("FAIL pre_reset_wrap_cnt: got %0d want 1", wrap_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pe, cep, cet, d, busy, err, wrap_cnt} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL async_reset: pe=%b cep=%b cet=%b d=%0d busy=%b err=%b wrap_cnt=%0d, want 1 0 0 0 0 0 0",
               pe, cep, cet, d, busy, err, wrap_cnt);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (pe !== 1'b1 || busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle: pe=%b busy=%b want pe=1 busy=0", pe, busy);
      end
    end
  endtask

  task automatic test_mod10;
    int wraps;
    logic [3:0] exp_q;
    do_reset();
    mod_n = 4'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (pe !== 1'b0 || d !== 4'd6 || busy !== 1'b1) begin
      errors++; $display("FAIL mod10_load: pe=%b d=%0d busy=%b want pe=0 d=6 busy=1", pe, d, busy);
    end
    step();
    wraps = 0;
    for (int i = 0; i < 30; i++) begin
      exp_q = 4'd6 + 4'(i % 10);
      checks++;
      if (q_in !== exp_q || pe !== (exp_q != 4'd15) || cep !== 1'b1) begin
        errors++;
        $display("FAIL mod10_seq[%0d]: q=%0d pe=%b cep=%b want q=%0d pe=%b cep=1", i, q_in, pe, cep, exp_q, exp_q != 4'd15);
      end
      step();
      if (wrap) wraps++;
    end
    checks++;
    if (wraps != 3 || wrap_cnt !== 8'd3 || err !== 1'b0) begin
      errors++; $display("FAIL mod10_wraps: pulses=%0d wrap_cnt=%0d err=%b want 3 3 0", wraps, wrap_cnt, err);
    end
  endtask

  task automatic test_pause_resume;
    do_reset();
    start_run(4'd10);
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (cep !== 1'b0 || cet !== 1'b0 || q_in !== 4'd9 || busy !== 1'b1) begin
      errors++; $display("FAIL pause_enter: cep=%b cet=%b q=%0d busy=%b want 0 0 9 1", cep, cet, q_in, busy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q_in !== 4'd9 || pe !== 1'b1) begin
        errors++; $display("FAIL pause_hold[%0d]: q=%0d pe=%b want q=9 pe=1", i, q_in, pe);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (cep !== 1'b1 || pe !== 1'b1 || q_in !== 4'd9) begin
      errors++; $display("FAIL resume: cep=%b pe=%b q=%0d want 1 1 9", cep, pe, q_in);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (q_in !== 4'(10 + i) || pe !== 1'b1 || err !== 1'b0) begin
        errors++; $display("FAIL resume_count[%0d]: q=%0d pe=%b err=%b want q=%0d pe=1 err=0", i, q_in, pe, err, 10 + i);
      end
    end
  endtask

  task automatic test_illegal_mod;
    do_reset();
    mod_n = 4'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || pe !== 1'b1 || cep !== 1'b0) begin
      errors++; $display("FAIL mod1_err: err=%b busy=%b pe=%b cep=%b want 1 0 1 0", err, busy, pe, cep);
    end
    step();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL mod1_sticky: err=%b busy=%b want 1 0", err, busy);
    end
    mod_n = 4'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (pe !== 1'b0 || d !== 4'd13) begin
      errors++; $display("FAIL mod3_load: pe=%b d=%0d want pe=0 d=13", pe, d);
    end
    step();
    checks++;
    if (err !== 1'b0 || q_in !== 4'd13) begin
      errors++; $display("FAIL mod3_clear: err=%b q=%0d want err=0 q=13", err, q_in);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (q_in !== 4'd13 || wrap !== 1'b1 || wrap_cnt !== 8'd1) begin
      errors++; $display("FAIL mod3_period: q=%0d wrap=%b wrap_cnt=%0d want 13 1 1", q_in, wrap, wrap_cnt);
    end
  endtask

  task automatic test_mod16;
    int wraps;
    do_reset();
    mod_n = 4'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (pe !== 1'b0 || d !== 4'd0) begin
      errors++; $display("FAIL mod16_load: pe=%b d=%0d want pe=0 d=0", pe, d);
    end
    step();
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 3) mod_n = 4'd5;
      checks++;
      if (q_in !== 4'(i % 16)) begin
        errors++; $display("FAIL mod16_seq[%0d]: q=%0d want %0d", i, q_in, i % 16);
      end
      step();
      if (wrap) wraps++;
    end
    checks++;
    if (wraps != 2 || wrap_cnt !== 8'd2) begin
      errors++; $display("FAIL mod16_wraps: pulses=%0d wrap_cnt=%0d want 2 2", wraps, wrap_cnt);
    end
  endtask

  task automatic test_fault;
    do_reset();
    start_run(4'd10);
    step();
    fault_en = 1'b1;
    fault_val = 4'd4;
    #1;
    checks++;
    if (err !== 1'b0 || q !== 4'd7) begin
      errors++; $display("FAIL fault_pre: err=%b q=%0d want err=0 q=7", err, q);
    end
    step();
    fault_en = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL fault_detect: err=%b want 1", err);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL fault_sticky: err=%b want 1", err);
    end
    stop = 1'b1;
    step();
    step();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1 || pe !== 1'b1) begin
      errors++; $display("FAIL fault_stop_idle: busy=%b err=%b pe=%b want 0 1 1", busy, err, pe);
    end
    start = 1'b1;
    stop = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0 || pe !== 1'b1 || cep !== 1'b0) begin
      errors++; $display("FAIL start_stop_idle: busy=%b pe=%b cep=%b want 0 1 0", busy, pe, cep);
    end
    stop = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (pe !== 1'b0 || err !== 1'b1) begin
      errors++; $display("FAIL restart_load: pe=%b err=%b want pe=0 err=1", pe, err);
    end
    step();
    checks++;
    if (err !== 1'b0 || q_in !== 4'd6) begin
      errors++; $display("FAIL restart_clear: err=%b q=%0d want err=0 q=6", err, q_in);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; mod_n = 4'd0; fault_en = 1'b0; fault_val = 4'd0;
    test_reset();
    test_mod10();
    test_pause_resume();
    test_illegal_mod();
    test_mod16();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
